sevenseg_scan_driver: RTL

//  Multiplexed 8-digit seven-segment scan driver that consumes the 32-bit debug/display word
//  (core debug_output or mmio disp_out) and drives the board's active-low segment and anode pins.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/ce_prescaler.sv | 39 +++
 rtl/sevenseg_scan_driver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
//------------------------------------------------------------------------------
// seg7_pkg : seven-segment shared types, constants and the hex glyph decoder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   typedef logic [2:0] digit_idx_t;

   // Active-low segments, bit6 = a .. bit0 = g.
   function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ce_prescaler.sv
//------------------------------------------------------------------------------
// ce_prescaler : free-running slot counter 0..DIV-1 with a terminal-count tick.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ce_prescaler #(
   parameter int DIV   = 1000,
   parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic             clk,
   input  logic             Rst,
   output logic             tick,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == c_last);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan_driver.sv
//------------------------------------------------------------------------------
// sevenseg_scan_driver : 8-digit multiplexed seven-segment scan driver with
// frame-coherent snapshot, leading-zero blanking, decimal points and PWM dimming.
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sevenseg_scan_driver
   import seg7_pkg::*;
#(
   parameter int CLK_DIV   = 1000,
   parameter int BLANK_CYC = 8,
   parameter int PWM_BITS  = 4
) (
   input  logic                clk,
   input  logic                Rst,
   input  logic [31:0]         disp_value,
   input  logic                disp_en,
   input  logic                blank_lz,
   input  logic [7:0]          dp_mask,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [6:0]          sev_out,
   output logic                dp_n,
   output logic [7:0]          an,
   output logic                frame_strobe
);

   localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] c_blank = CNT_W'(BLANK_CYC);

   logic             slot_tick;
   logic [CNT_W-1:0] slot_cnt;

   ce_prescaler #(
      .DIV   (CLK_DIV),
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk  (clk),
      .Rst  (Rst),
      .tick (slot_tick),
      .cnt  (slot_cnt)
   );

   digit_idx_t          idx_q, idx_d;
   logic [31:0]         shadow_q, shadow_d;
   logic [7:0]          shadow_dp_q, shadow_dp_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                frame_strobe_q, frame_strobe_d;
   logic [7:0]          an_q, an_d;
   logic [6:0]          sev_q, sev_d;
   logic                dp_n_q, dp_n_d;

   logic                frame_wrap;
   digit_idx_t          lz_top;
   logic                lz_blank;
   logic                digit_dp;
   logic                lit;

   always_comb begin
      lz_top = '0;
      for (int i = 0; i < 8; i++) begin
         if (shadow_q[4*i +: 4] != 4'h0) begin
            lz_top = digit_idx_t'(i);
         end
      end
   end

   always_comb begin
      frame_wrap     = slot_tick && (idx_q == 3'd7);
      idx_d          = slot_tick ? idx_q + 3'd1 : idx_q;
      shadow_d       = frame_wrap ? disp_value : shadow_q;
      shadow_dp_d    = frame_wrap ? dp_mask : shadow_dp_q;
      frame_strobe_d = frame_wrap;
      pwm_cnt_d      = pwm_cnt_q + 1'b1;

      // A lit decimal point keeps a blanked leading digit's anode on, segments dark.
      digit_dp = shadow_dp_q[idx_q];
      lz_blank = blank_lz && (idx_q > lz_top);
      lit      = disp_en && (pwm_cnt_q <= brightness) && (slot_cnt >= c_blank)
                 && (!lz_blank || digit_dp);

      an_d   = AN_OFF;
      sev_d  = SEG_OFF;
      dp_n_d = 1'b1;
      if (lit) begin
         an_d   = ~(8'd1 << idx_q);
         sev_d  = lz_blank ? SEG_OFF : hex_to_seg7(shadow_q[{idx_q, 2'b00} +: 4]);
         dp_n_d = ~digit_dp;
      end
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         idx_q          <= '0;
         shadow_q       <= '0;
         shadow_dp_q    <= '0;
         pwm_cnt_q      <= '0;
         frame_strobe_q <= 1'b0;
         an_q           <= AN_OFF;
         sev_q          <= SEG_OFF;
         dp_n_q         <= 1'b1;
      end else begin
         idx_q          <= idx_d;
         shadow_q       <= shadow_d;
         shadow_dp_q    <= shadow_dp_d;
         pwm_cnt_q      <= pwm_cnt_d;
         frame_strobe_q <= frame_strobe_d;
         an_q           <= an_d;
         sev_q          <= sev_d;
         dp_n_q         <= dp_n_d;
      end
   end

   assign an           = an_q;
   assign sev_out      = sev_q;
   assign dp_n         = dp_n_q;
   assign frame_strobe = frame_strobe_q;

endmodule

`default_nettype wire
